// File: rtl/axis_tdest_demux.sv
`default_nettype none
// ============================================================================
// Module   : axis_tdest_demux
// Brief    : Steers whole AXI-Stream packets to one of M_COUNT ports by tdest
//            latched on the first beat; drops out-of-range packets; counts
//            completed and dropped packets.
// Revision : 1.0 - initial release
// ============================================================================
module axis_tdest_demux #(
  parameter int AXIS_DATA_WIDTH = 64,
  parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
  parameter int AXIS_DEST_WIDTH = 3,
  parameter int M_COUNT         = 4,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [AXIS_DATA_WIDTH-1:0]           s_axis_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0]           s_axis_tkeep,
  input  logic [AXIS_DEST_WIDTH-1:0]           s_axis_tdest,
  input  logic                                 s_axis_tvalid,
  output logic                                 s_axis_tready,
  input  logic                                 s_axis_tlast,
  output logic [M_COUNT*AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [M_COUNT*AXIS_KEEP_WIDTH-1:0]   m_axis_tkeep,
  output logic [M_COUNT-1:0]                   m_axis_tvalid,
  input  logic [M_COUNT-1:0]                   m_axis_tready,
  output logic [M_COUNT-1:0]                   m_axis_tlast,
  output logic [M_COUNT*CNT_WIDTH-1:0]         pkt_count,
  output logic [CNT_WIDTH-1:0]                 drop_count,
  input  logic                                 clr_counters,
  output logic                                 busy
);

  localparam logic [AXIS_DEST_WIDTH:0] c_m_count = (AXIS_DEST_WIDTH+1)'(M_COUNT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FORWARD = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t                     r_state;
  state_t                     w_state_next;
  logic [AXIS_DEST_WIDTH-1:0] r_sel;
  logic [M_COUNT-1:0]         w_can_load;
  logic                       w_dest_ok;
  logic                       w_rdy_dest;
  logic                       w_rdy_sel;
  logic                       w_tready;
  logic                       w_acc;
  logic                       w_fwd_en;
  logic [AXIS_DEST_WIDTH-1:0] w_fwd_idx;
  logic                       w_drop_inc;
  logic [CNT_WIDTH-1:0]       r_drop_cnt;

  assign w_dest_ok = {1'b0, s_axis_tdest} < c_m_count;

  always_comb begin
    w_rdy_dest = 1'b0;
    w_rdy_sel  = 1'b0;
    for (int i = 0; i < M_COUNT; i++) begin
      if (s_axis_tdest == AXIS_DEST_WIDTH'(i)) w_rdy_dest = w_can_load[i];
      if (r_sel == AXIS_DEST_WIDTH'(i))        w_rdy_sel  = w_can_load[i];
    end
  end

  // Ready never looks at s_axis_tvalid, so it is safe for upstream to wait on it.
  always_comb begin
    w_tready = 1'b0;
    case (r_state)
      S_IDLE:    w_tready = w_dest_ok ? w_rdy_dest : 1'b1;
      S_FORWARD: w_tready = w_rdy_sel;
      S_DISCARD: w_tready = 1'b1;
      default:   w_tready = 1'b0;
    endcase
  end

  assign s_axis_tready = w_tready & rst_n;
  assign w_acc         = s_axis_tvalid & s_axis_tready;
  assign busy          = (r_state != S_IDLE);
  assign drop_count    = r_drop_cnt;

  always_comb begin
    w_state_next = r_state;
    w_fwd_en     = 1'b0;
    w_fwd_idx    = r_sel;
    w_drop_inc   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_fwd_idx = s_axis_tdest;
        if (w_acc) begin
          if (w_dest_ok) begin
            w_fwd_en = 1'b1;
            if (!s_axis_tlast) w_state_next = S_FORWARD;
          end else begin
            w_drop_inc = 1'b1;
            if (!s_axis_tlast) w_state_next = S_DISCARD;
          end
        end
      end
      S_FORWARD: begin
        if (w_acc) begin
          w_fwd_en = 1'b1;
          if (s_axis_tlast) w_state_next = S_IDLE;
        end
      end
      S_DISCARD: begin
        if (w_acc && s_axis_tlast) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_sel   <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_IDLE && w_acc && w_dest_ok) r_sel <= s_axis_tdest;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            r_drop_cnt <= '0;
    else if (clr_counters) r_drop_cnt <= '0;
    else if (w_drop_inc)   r_drop_cnt <= r_drop_cnt + CNT_WIDTH'(1);
  end

  generate
    for (genvar i = 0; i < M_COUNT; i++) begin : g_port
      logic [AXIS_DATA_WIDTH-1:0] r_tdata;
      logic [AXIS_KEEP_WIDTH-1:0] r_tkeep;
      logic                       r_tvalid;
      logic                       r_tlast;
      logic [CNT_WIDTH-1:0]       r_pkt_cnt;
      logic                       w_load;

      assign w_can_load[i] = ~r_tvalid | m_axis_tready[i];
      assign w_load        = w_fwd_en && (w_fwd_idx == AXIS_DEST_WIDTH'(i));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_tdata  <= '0;
          r_tkeep  <= '0;
          r_tvalid <= 1'b0;
          r_tlast  <= 1'b0;
        end else if (w_load) begin
          r_tdata  <= s_axis_tdata;
          r_tkeep  <= s_axis_tkeep;
          r_tvalid <= 1'b1;
          r_tlast  <= s_axis_tlast;
        end else if (m_axis_tready[i]) begin
          r_tvalid <= 1'b0;
          r_tlast  <= 1'b0;
        end
      end

      // Count on acceptance of the tlast beat, not when it leaves the port.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  r_pkt_cnt <= '0;
        else if (clr_counters)       r_pkt_cnt <= '0;
        else if (w_load && s_axis_tlast) r_pkt_cnt <= r_pkt_cnt + CNT_WIDTH'(1);
      end

      assign m_axis_tdata[i*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH] = r_tdata;
      assign m_axis_tkeep[i*AXIS_KEEP_WIDTH +: AXIS_KEEP_WIDTH] = r_tkeep;
      assign m_axis_tvalid[i]                                   = r_tvalid;
      assign m_axis_tlast[i]                                    = r_tlast;
      assign pkt_count[i*CNT_WIDTH +: CNT_WIDTH]                = r_pkt_cnt;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_axis_tdest_demux.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_tdest_demux
// Brief    : Directed self-checking bench for axis_tdest_demux.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_tdest_demux;

  localparam int DW  = 64;
  localparam int KW  = 8;
  localparam int DSW = 3;
  localparam int MC  = 4;
  localparam int CW  = 32;
  localparam int CW2 = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [DW-1:0]     s_tdata = '0;
  logic [KW-1:0]     s_tkeep = '0;
  logic [DSW-1:0]    s_tdest = '0;
  logic              s_tvalid = 1'b0;
  logic              s_tlast = 1'b0;
  logic              s_tready;
  logic [MC*DW-1:0]  m_tdata;
  logic [MC*KW-1:0]  m_tkeep;
  logic [MC-1:0]     m_tvalid;
  logic [MC-1:0]     m_tready = '1;
  logic [MC-1:0]     m_tlast;
  logic [MC*CW-1:0]  pkt_count;
  logic [CW-1:0]     drop_count;
  logic              clr = 1'b0;
  logic              busy;

  logic              s_tready2;
  logic [MC*DW-1:0]  m_tdata2;
  logic [MC*KW-1:0]  m_tkeep2;
  logic [MC-1:0]     m_tvalid2;
  logic [MC-1:0]     m_tlast2;
  logic [MC*CW2-1:0] pkt_count2;
  logic [CW2-1:0]    drop_count2;
  logic              busy2;

  int errors = 0;
  int checks = 0;
  int wait_cycles;
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];

  always #5 clk = ~clk;

  axis_tdest_demux #(.AXIS_DATA_WIDTH(DW), .AXIS_KEEP_WIDTH(KW), .AXIS_DEST_WIDTH(DSW),
                     .M_COUNT(MC), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tdest(s_tdest),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
    .pkt_count(pkt_count), .drop_count(drop_count), .clr_counters(clr), .busy(busy)
  );

  // Narrow-counter copy on the same stream to exercise wraparound quickly.
  axis_tdest_demux #(.AXIS_DATA_WIDTH(DW), .AXIS_KEEP_WIDTH(KW), .AXIS_DEST_WIDTH(DSW),
                     .M_COUNT(MC), .CNT_WIDTH(CW2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tdest(s_tdest),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready2), .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata2), .m_axis_tkeep(m_tkeep2), .m_axis_tvalid(m_tvalid2),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast2),
    .pkt_count(pkt_count2), .drop_count(drop_count2), .clr_counters(clr), .busy(busy2)
  );

  always @(posedge clk) begin
    if (rst_n && m_tvalid[0] && m_tready[0]) q0.push_back(m_tdata[0*DW +: DW]);
    if (rst_n && m_tvalid[1] && m_tready[1]) q1.push_back(m_tdata[1*DW +: DW]);
  end

  function automatic logic [CW-1:0] pc(input int i);
    return pkt_count[i*CW +: CW];
  endfunction

  function automatic logic [DW-1:0] pd(input int i);
    return m_tdata[i*DW +: DW];
  endfunction

  task automatic send_beat(input logic [DW-1:0] d, input logic [DSW-1:0] dest, input logic last);
    s_tdata = d; s_tkeep = 8'hFF; s_tdest = dest; s_tlast = last; s_tvalid = 1'b1;
    wait_cycles = 0;
    #1;
    while (!s_tready && wait_cycles < 100) begin
      @(posedge clk); #2;
      wait_cycles++;
    end
    if (!s_tready) begin
      errors++; checks++;
      $display("FAIL send_timeout: tready=%0b after %0d cycles, required 1", s_tready, wait_cycles);
    end
    @(posedge clk); #1;
    s_tvalid = 1'b0;
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    s_tvalid = 1'b1; s_tdest = 3'd0;
    #10;
    checks++; if (m_tvalid !== 4'b0 || m_tlast !== 4'b0) begin errors++; $display("FAIL reset_valid_last: valid=%b last=%b required 0", m_tvalid, m_tlast); end
    checks++; if (m_tdata !== '0 || m_tkeep !== '0) begin errors++; $display("FAIL reset_data_keep: data=%h keep=%h required 0", m_tdata, m_tkeep); end
    checks++; if (pkt_count !== '0 || drop_count !== '0) begin errors++; $display("FAIL reset_counters: pkt=%h drop=%h required 0", pkt_count, drop_count); end
    checks++; if (s_tready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_ready_busy: tready=%b busy=%b required 0 0", s_tready, busy); end
    s_tvalid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_forward3;
    checks++; if (m_tvalid !== 4'b0) begin errors++; $display("FAIL fwd_idle_valid: %b required 0000", m_tvalid); end
    send_beat(64'hA0, 3'd2, 1'b0);
    checks++; if (m_tvalid !== 4'b0100 || m_tlast !== 4'b0 || pd(2) !== 64'hA0) begin errors++; $display("FAIL fwd_beat1: valid=%b last=%b data=%h required 0100 0000 a0", m_tvalid, m_tlast, pd(2)); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fwd_busy: %b required 1", busy); end
    send_beat(64'hA1, 3'd7, 1'b0);
    checks++; if (m_tvalid !== 4'b0100 || m_tlast !== 4'b0 || pd(2) !== 64'hA1) begin errors++; $display("FAIL fwd_beat2: valid=%b last=%b data=%h required 0100 0000 a1", m_tvalid, m_tlast, pd(2)); end
    send_beat(64'hA2, 3'd0, 1'b1);
    checks++; if (m_tvalid !== 4'b0100 || m_tlast !== 4'b0100 || pd(2) !== 64'hA2) begin errors++; $display("FAIL fwd_beat3: valid=%b last=%b data=%h required 0100 0100 a2", m_tvalid, m_tlast, pd(2)); end
    checks++; if (pc(2) !== 32'd1 || busy !== 1'b0) begin errors++; $display("FAIL fwd_count: pkt2=%0d busy=%b required 1 0", pc(2), busy); end
    @(posedge clk); #1;
    checks++; if (m_tvalid !== 4'b0 || m_tlast !== 4'b0) begin errors++; $display("FAIL fwd_drain: valid=%b last=%b required 0", m_tvalid, m_tlast); end
  endtask

  task automatic test_back_to_back;
    send_beat(64'h11, 3'd1, 1'b1);
    checks++; if (wait_cycles != 0 || m_tvalid !== 4'b0010 || busy !== 1'b0) begin errors++; $display("FAIL b2b_first: waits=%0d valid=%b busy=%b required 0 0010 0", wait_cycles, m_tvalid, busy); end
    send_beat(64'h33, 3'd3, 1'b1);
    checks++; if (wait_cycles != 0 || m_tvalid !== 4'b1000 || pd(3) !== 64'h33 || busy !== 1'b0) begin errors++; $display("FAIL b2b_second: waits=%0d valid=%b data=%h busy=%b required 0 1000 33 0", wait_cycles, m_tvalid, pd(3), busy); end
    checks++; if (pc(1) !== 32'd1 || pc(3) !== 32'd1) begin errors++; $display("FAIL b2b_counts: pkt1=%0d pkt3=%0d required 1 1", pc(1), pc(3)); end
    @(posedge clk); #1;
  endtask

  task automatic test_drop;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL drop_busy: beat %0d busy=%b required 1", k + 1, busy); end
      end
      send_beat(64'hD0 + 64'(k), 3'd5, (k == 3));
      checks++; if (wait_cycles != 0 || m_tvalid !== 4'b0) begin errors++; $display("FAIL drop_beat: beat %0d waits=%0d valid=%b required 0 0000", k + 1, wait_cycles, m_tvalid); end
    end
    checks++; if (drop_count !== 32'd1 || busy !== 1'b0) begin errors++; $display("FAIL drop_count: drop=%0d busy=%b required 1 0", drop_count, busy); end
  endtask

  task automatic test_backpressure;
    q0.delete(); q1.delete();
    m_tready = 4'b1110;
    send_beat(64'hB0, 3'd0, 1'b0);
    s_tdata = 64'hB1; s_tdest = 3'd1; s_tlast = 1'b0; s_tvalid = 1'b1;
    #1;
    for (int c = 0; c < 5; c++) begin
      checks++; if (s_tready !== 1'b0 || m_tvalid[1] !== 1'b0) begin errors++; $display("FAIL bp_stall: cycle %0d tready=%b valid1=%b required 0 0", c, s_tready, m_tvalid[1]); end
      @(posedge clk); #1;
    end
    m_tready = 4'b1111;
    send_beat(64'hB1, 3'd1, 1'b0);
    send_beat(64'hB2, 3'd1, 1'b0);
    send_beat(64'hB3, 3'd1, 1'b1);
    send_beat(64'hC1, 3'd1, 1'b1);
    @(posedge clk); @(posedge clk); #1;
    checks++; if (q0.size() != 4) begin errors++; $display("FAIL bp_port0_len: %0d beats required 4", q0.size()); end
    for (int k = 0; k < 4 && k < q0.size(); k++) begin
      checks++; if (q0[k] !== 64'hB0 + 64'(k)) begin errors++; $display("FAIL bp_port0_order: beat %0d data=%h required %h", k, q0[k], 64'hB0 + 64'(k)); end
    end
    checks++; if (q1.size() != 1 || q1[0] !== 64'hC1) begin errors++; $display("FAIL bp_port1: %0d beats first=%h required 1 c1", q1.size(), (q1.size() > 0) ? q1[0] : 64'h0); end
    checks++; if (pc(0) !== 32'd1 || pc(1) !== 32'd2) begin errors++; $display("FAIL bp_counts: pkt0=%0d pkt1=%0d required 1 2", pc(0), pc(1)); end
  endtask

  task automatic test_async_reset;
    send_beat(64'hE0, 3'd2, 1'b0);
    s_tdata = 64'hE1; s_tdest = 3'd1; s_tlast = 1'b0; s_tvalid = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    checks++; if (m_tvalid !== 4'b0 || m_tlast !== 4'b0 || m_tdata !== '0 || m_tkeep !== '0) begin errors++; $display("FAIL arst_outputs: valid=%b last=%b data=%h required 0", m_tvalid, m_tlast, m_tdata); end
    checks++; if (pkt_count !== '0 || drop_count !== '0) begin errors++; $display("FAIL arst_counters: pkt=%h drop=%h required 0", pkt_count, drop_count); end
    checks++; if (busy !== 1'b0 || s_tready !== 1'b0) begin errors++; $display("FAIL arst_state: busy=%b tready=%b required 0 0", busy, s_tready); end
    @(posedge clk); #3 rst_n = 1'b1;
    send_beat(64'hE1, 3'd1, 1'b0);
    checks++; if (m_tvalid !== 4'b0010 || pd(1) !== 64'hE1 || busy !== 1'b1) begin errors++; $display("FAIL arst_newpkt: valid=%b data=%h busy=%b required 0010 e1 1", m_tvalid, pd(1), busy); end
    send_beat(64'hE2, 3'd2, 1'b1);
    checks++; if (m_tvalid !== 4'b0010 || m_tlast !== 4'b0010 || pc(1) !== 32'd1 || pc(2) !== 32'd0) begin errors++; $display("FAIL arst_tail: valid=%b last=%b pkt1=%0d pkt2=%0d required 0010 0010 1 0", m_tvalid, m_tlast, pc(1), pc(2)); end
  endtask

  task automatic test_counter_wrap;
    for (int k = 0; k < 7; k++) send_beat(64'h50 + 64'(k), 3'd0, 1'b1);
    checks++; if (pkt_count2[0 +: CW2] !== 3'd7 || pc(0) !== 32'd7) begin errors++; $display("FAIL wrap_pre: narrow=%0d wide=%0d required 7 7", pkt_count2[0 +: CW2], pc(0)); end
    send_beat(64'h57, 3'd0, 1'b1);
    checks++; if (pkt_count2[0 +: CW2] !== 3'd0 || pc(0) !== 32'd8) begin errors++; $display("FAIL wrap_roll: narrow=%0d wide=%0d required 0 8", pkt_count2[0 +: CW2], pc(0)); end
    for (int k = 0; k < 7; k++) send_beat(64'h60 + 64'(k), 3'd0, 1'b1);
    checks++; if (pkt_count2[0 +: CW2] !== 3'd7) begin errors++; $display("FAIL wrap_pre2: narrow=%0d required 7", pkt_count2[0 +: CW2]); end
    clr = 1'b1;
    send_beat(64'h67, 3'd0, 1'b1);
    clr = 1'b0;
    checks++; if (pkt_count2[0 +: CW2] !== 3'd0 || pc(0) !== 32'd0 || pc(1) !== 32'd0) begin errors++; $display("FAIL wrap_clr_prio: narrow=%0d wide0=%0d wide1=%0d required 0 0 0", pkt_count2[0 +: CW2], pc(0), pc(1)); end
  endtask

  task automatic test_clear_idle;
    send_beat(64'h71, 3'd3, 1'b1);
    send_beat(64'h72, 3'd6, 1'b1);
    checks++; if (pc(3) !== 32'd1 || drop_count !== 32'd1) begin errors++; $display("FAIL clr_pre: pkt3=%0d drop=%0d required 1 1", pc(3), drop_count); end
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    checks++; if (pkt_count !== '0 || drop_count !== '0 || pkt_count2 !== '0 || drop_count2 !== '0) begin errors++; $display("FAIL clr_idle: pkt=%h drop=%0d required 0 0", pkt_count, drop_count); end
  endtask

  initial begin
    test_reset();
    test_forward3();
    test_back_to_back();
    test_drop();
    test_backpressure();
    test_async_reset();
    test_counter_wrap();
    test_clear_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axis_tdest_demux.md
Name: axis_tdest_demux

Overview:
- Sits directly downstream of the packet dispatcher FSM and consumes its tdest-tagged AXI-Stream output.
- Steers each packet, whole, to one of M_COUNT output streams selected by tdest. tdest is latched on the first beat of the packet.
- Discards packets whose tdest is out of range.
- Keeps per-port packet counters and an invalid-dest drop counter for the host control path.

Parameters:
- AXIS_DATA_WIDTH, 64: stream data width.
- AXIS_KEEP_WIDTH, AXIS_DATA_WIDTH/8: tkeep width.
- AXIS_DEST_WIDTH, 3: tdest width.
- M_COUNT, 4: number of output ports, 1..2^AXIS_DEST_WIDTH.
- CNT_WIDTH, 32: statistics counter width.

Ports:
- clk  in  1  sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  AXIS_DATA_WIDTH  input data.
- s_axis_tkeep  in  AXIS_KEEP_WIDTH  input byte enables.
- s_axis_tdest  in  AXIS_DEST_WIDTH  destination; sampled on the first beat only.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  end of packet.
- m_axis_tdata  out  M_COUNT*AXIS_DATA_WIDTH  per-port data; port i occupies slice i.
- m_axis_tkeep  out  M_COUNT*AXIS_KEEP_WIDTH  per-port keep.
- m_axis_tvalid  out  M_COUNT  per-port valid.
- m_axis_tready  in  M_COUNT  per-port ready.
- m_axis_tlast  out  M_COUNT  per-port last.
- pkt_count  out  M_COUNT*CNT_WIDTH  packets completed per port.
- drop_count  out  CNT_WIDTH  packets discarded for invalid dest.
- clr_counters  in  1  synchronous clear of all counters.
- busy  out  1  high while mid-packet (state != IDLE).

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE, sel = 0.
  - All m_axis_tvalid, m_axis_tlast, m_axis_tdata and m_axis_tkeep = 0.
  - All counters = 0; s_axis_tready = 0 while rst_n is low.
- Reset asserted mid-packet aborts the packet. The remaining input beats are then treated as a new packet, since the upstream stage is reset together with this block.
- Output stage: one register per port. Latency from input acceptance to m_axis_tvalid is 1 cycle.
  - A port register loads when its valid is 0 or its tready is 1.
  - A port's valid clears when its tready is 1 and no new beat loads.
- State machine, 2-bit state:
  - IDLE, waiting for the first beat:
    - s_axis_tready = 1 if tdest >= M_COUNT. Otherwise s_axis_tready = 1 if port[tdest] can load.
    - On a beat accepted with tdest < M_COUNT: sel <= tdest; beat loaded into port[tdest].
    - If that beat has tlast=1: stay in IDLE and increment pkt_count[tdest]. Otherwise go to FORWARD.
    - On a beat accepted with tdest >= M_COUNT: increment drop_count. If tlast=1 stay in IDLE, otherwise go to DISCARD.
  - FORWARD:
    - s_axis_tready = port[sel] can load; tdest is ignored.
    - On an accepted beat with tlast: increment pkt_count[sel], go to IDLE.
  - DISCARD:
    - s_axis_tready = 1; beats are consumed and not forwarded.
    - On an accepted beat with tlast: go to IDLE.
  - Unused encoding: go to IDLE.
- tready is combinational from state, tdest and the downstream port readiness. It never depends on s_axis_tvalid.
- Ports other than sel are unaffected by the active packet. They continue to drain their held beat.
- Counters:
  - Wrap modulo 2^CNT_WIDTH.
  - clr_counters has priority over a same-cycle increment; the counter ends at 0.
  - pkt_count increments on acceptance of the tlast beat, not on its output.
- Zero-length packets cannot occur: every packet has at least one beat.

Test Plan:
- M_COUNT=4, all m_axis_tready=1, 3-beat packet with tdest=2:
  - m_axis_tvalid[2] high on cycles 1-3; m_axis_tlast[2] high on cycle 3 only.
  - Other ports' valid stays low; pkt_count[2] = 1.
- Single-beat packet tdest=1 followed back-to-back by a single-beat packet tdest=3:
  - Both forwarded with no bubble.
  - pkt_count[1] = 1 and pkt_count[3] = 1; state stays in IDLE throughout.
- 4-beat packet with tdest=5 (>= M_COUNT):
  - s_axis_tready = 1 for all 4 beats; no m_axis_tvalid rises.
  - drop_count = 1; busy high for beats 2-4.
- Port 0 tready held low for 5 cycles during a 4-beat tdest=0 packet:
  - s_axis_tready drops after the first beat is held.
  - Data order is preserved and no beat is lost or duplicated.
  - Port 1 traffic queued behind it waits until after the tlast beat is accepted.
- Preload pkt_count[0] = 2^32-1, then send one packet to port 0 with clr_counters pulsed on the tlast-acceptance cycle:
  - Without the clear the counter wraps to 0; with the clear it also reads 0.
  - Pulsing clr_counters on a later idle cycle zeroes all counters.
- rst_n pulled low for 1 cycle, asynchronous to clk, during beat 2 of a FORWARD packet:
  - All outputs and counters go to 0 immediately; state = IDLE.
  - The next accepted beat's tdest selects the port.
